// File: rtl/scan_chain_ctrl_if.sv
// Host/chain bundle for scan_chain_ctrl. The slave modport is the controller side.
// SCAN_COMPARE_EN adds expected_in/fail for on-chip response comparison.
`timescale 1ns/1ps
interface scan_chain_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 8
);
  logic                 start;
  logic [CHAIN_LEN-1:0] pattern_in;
  logic                 scan_so;
  logic                 scan_en;
  logic                 scan_si;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] response;
`ifdef SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] expected_in;
  logic                 fail;

  modport slave  (input  start, pattern_in, scan_so, expected_in,
                  output scan_en, scan_si, busy, done, response, fail);
  modport master (output start, pattern_in, scan_so, expected_in,
                  input  scan_en, scan_si, busy, done, response, fail);
`else
  modport slave  (input  start, pattern_in, scan_so,
                  output scan_en, scan_si, busy, done, response);
  modport master (output start, pattern_in, scan_so,
                  input  scan_en, scan_si, busy, done, response);
`endif
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan-chain sequencer: shift pattern in, one capture cycle, shift response out.
// Optional macro SCAN_COMPARE_EN adds a registered response-vs-expected fail flag.
`timescale 1ns/1ps
module scan_chain_ctrl #(
  parameter  int unsigned CHAIN_LEN = 8,
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input logic              clk,
  input logic              rst,
  scan_chain_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_sr;
  logic [CHAIN_LEN-1:0] resp_sr;
  logic [CHAIN_LEN-1:0] resp_shift;
  logic [CHAIN_LEN-1:0] response;
  logic                 scan_en;
  logic                 scan_si;
  logic                 busy;
  logic                 done;
`ifdef SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_lat;
  logic                 fail;
  assign bus.fail = fail;
`endif

  // Includes the sample taken on the current edge, so response sees all CHAIN_LEN bits.
  assign resp_shift   = {resp_sr[CHAIN_LEN-2:0], bus.scan_so};
  assign bus.scan_en  = scan_en;
  assign bus.scan_si  = scan_si;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.response = response;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pat_sr   <= '0;
      resp_sr  <= '0;
      response <= '0;
      scan_en  <= 1'b0;
      scan_si  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SCAN_COMPARE_EN
      exp_lat  <= '0;
      fail     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SHIFT_IN;
            cnt     <= '0;
            // MSB is presented right away; the shifted copy feeds later edges.
            scan_si <= bus.pattern_in[CHAIN_LEN-1];
            pat_sr  <= bus.pattern_in << 1;
            scan_en <= 1'b1;
            busy    <= 1'b1;
`ifdef SCAN_COMPARE_EN
            exp_lat <= bus.expected_in;
`endif
          end
        end
        SHIFT_IN: begin
          if (cnt == LAST) begin
            state   <= CAPTURE;
            cnt     <= '0;
            scan_en <= 1'b0;
            scan_si <= 1'b0;
          end else begin
            cnt     <= cnt + 1'b1;
            scan_si <= pat_sr[CHAIN_LEN-1];
            pat_sr  <= pat_sr << 1;
          end
        end
        CAPTURE: begin
          state   <= SHIFT_OUT;
          cnt     <= '0;
          scan_en <= 1'b1;
        end
        SHIFT_OUT: begin
          resp_sr <= resp_shift;
          if (cnt == LAST) begin
            state    <= DONE;
            cnt      <= '0;
            scan_en  <= 1'b0;
            done     <= 1'b1;
            response <= resp_shift;
`ifdef SCAN_COMPARE_EN
            fail     <= |(resp_shift ^ exp_lat);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl: 8-FF and 2-FF behavioural scan chains
// with selectable functional input (inverted q or a fixed word).
`timescale 1ns/1ps
module tb_scan_chain_ctrl;
  localparam int unsigned CL  = 8;
  localparam int unsigned CL2 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_chain_ctrl_if #(.CHAIN_LEN(CL))  bus8 ();
  scan_chain_ctrl_if #(.CHAIN_LEN(CL2)) bus2 ();

  scan_chain_ctrl #(.CHAIN_LEN(CL))  dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  scan_chain_ctrl #(.CHAIN_LEN(CL2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // Scanned flip-flop chains: FF[0] fed by scan_si, FF[last] drives scan_so.
  logic [CL-1:0]  chain8 = '0;
  logic [CL2-1:0] chain2 = '0;
  logic           func_mode = 1'b0;   // 0: functional d = ~q, 1: d = fixed_val
  logic [CL-1:0]  fixed_val = '0;
  logic [CL-1:0]  exp8 = '0;

  always @(posedge clk) begin
    if (bus8.scan_en) chain8 <= {chain8[CL-2:0], bus8.scan_si};
    else              chain8 <= func_mode ? fixed_val : ~chain8;
    if (bus2.scan_en) chain2 <= {chain2[CL2-2:0], bus2.scan_si};
    else              chain2 <= ~chain2;
  end
  assign bus8.scan_so = chain8[CL-1];
  assign bus2.scan_so = chain2[CL2-1];

  int passed = 0;
  int total  = 0;

  // Drives one sequence; k counts edges after the accept edge (done expected at k = 2*CL+1).
  task automatic run_seq8(input logic [CL-1:0] pat, output logic [CL-1:0] resp,
                          output int dk, output int en_low, output logic [CL-1:0] cap_chain);
    @(posedge clk); #1;
    bus8.pattern_in = pat;
`ifdef SCAN_COMPARE_EN
    bus8.expected_in = exp8;
`endif
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start      = 1'b0;
    bus8.pattern_in = ~pat;
`ifdef SCAN_COMPARE_EN
    bus8.expected_in = ~exp8;
`endif
    dk = -1; en_low = 0; resp = 'x; cap_chain = 'x;
    for (int k = 0; k < 100; k++) begin
      if (bus8.done) begin
        dk = k; resp = bus8.response;
        break;
      end
      if (!bus8.scan_en) begin
        en_low++; cap_chain = chain8;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_seq2(input logic [CL2-1:0] pat, output logic [CL2-1:0] resp, output int dk);
    @(posedge clk); #1;
    bus2.pattern_in = pat;
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    bus2.pattern_in = ~pat;
    dk = -1; resp = 'x;
    for (int k = 0; k < 100; k++) begin
      if (bus2.done) begin
        dk = k; resp = bus2.response;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus8.start = 1'b0; bus8.pattern_in = '0;
    bus2.start = 1'b0; bus2.pattern_in = '0;
`ifdef SCAN_COMPARE_EN
    bus8.expected_in = '0; bus2.expected_in = '0;
`endif
    #12;
    total++; if (bus8.scan_en !== 1'b0) $display("FAIL reset_scan_en: got %b expected 0", bus8.scan_en); else passed++;
    total++; if (bus8.scan_si !== 1'b0) $display("FAIL reset_scan_si: got %b expected 0", bus8.scan_si); else passed++;
    total++; if (bus8.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus8.busy); else passed++;
    total++; if (bus8.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus8.done); else passed++;
    total++; if (bus8.response !== 8'h00) $display("FAIL reset_response: got %h expected 00", bus8.response); else passed++;
    total++; if (bus2.busy !== 1'b0) $display("FAIL reset_busy2: got %b expected 0", bus2.busy); else passed++;
`ifdef SCAN_COMPARE_EN
    total++; if (bus8.fail !== 1'b0) $display("FAIL reset_fail: got %b expected 0", bus8.fail); else passed++;
`endif
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_inversion();
    logic [CL-1:0] resp, cap;
    int dk, en_low;
    func_mode = 1'b0;
    run_seq8(8'hA5, resp, dk, en_low, cap);
    total++; if (resp !== 8'h5A) $display("FAIL inv_response: got %h expected 5a", resp); else passed++;
    total++; if (dk + 1 !== 18) $display("FAIL inv_done_latency: got %0d expected 18", dk + 1); else passed++;
    total++; if (en_low !== 1) $display("FAIL inv_capture_cycles: got %0d expected 1", en_low); else passed++;
    total++; if (cap !== 8'hA5) $display("FAIL inv_chain_loaded: got %h expected a5", cap); else passed++;
    @(posedge clk); #1;
    total++; if (bus8.done !== 1'b0) $display("FAIL inv_done_pulse: got %b expected 0", bus8.done); else passed++;
    total++; if (bus8.busy !== 1'b0) $display("FAIL inv_busy_idle: got %b expected 0", bus8.busy); else passed++;
    total++; if (bus8.response !== 8'h5A) $display("FAIL inv_response_hold: got %h expected 5a", bus8.response); else passed++;
  endtask

  task automatic test_mid_reset();
    int ndone, nbusy;
    bus8.pattern_in = 8'hA5; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (bus8.scan_si !== 1'b1) $display("FAIL midrst_pre_scan_si: got %b expected 1", bus8.scan_si); else passed++;
    total++; if (bus8.busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b expected 1", bus8.busy); else passed++;
    rst = 1'b0;
    #1;
    total++; if (bus8.scan_en !== 1'b0) $display("FAIL midrst_scan_en: got %b expected 0", bus8.scan_en); else passed++;
    total++; if (bus8.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus8.busy); else passed++;
    total++; if (bus8.done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", bus8.done); else passed++;
    total++; if (bus8.scan_si !== 1'b0) $display("FAIL midrst_scan_si: got %b expected 0", bus8.scan_si); else passed++;
    total++; if (bus8.response !== 8'h00) $display("FAIL midrst_response: got %h expected 00", bus8.response); else passed++;
    #2 rst = 1'b1;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus8.done) ndone++;
      if (bus8.busy) nbusy++;
    end
    total++; if (ndone !== 0) $display("FAIL midrst_no_done: got %0d expected 0", ndone); else passed++;
    total++; if (nbusy !== 0) $display("FAIL midrst_no_busy: got %0d expected 0", nbusy); else passed++;
  endtask

  task automatic test_fixed_func();
    logic [CL-1:0] resp, cap;
    int dk, en_low;
    func_mode = 1'b1; fixed_val = 8'h3C;
    run_seq8(8'h00, resp, dk, en_low, cap);
    total++; if (resp !== 8'h3C) $display("FAIL fixed_resp_p00: got %h expected 3c", resp); else passed++;
    total++; if (cap !== 8'h00) $display("FAIL fixed_chain_p00: got %h expected 00", cap); else passed++;
    run_seq8(8'hFF, resp, dk, en_low, cap);
    total++; if (resp !== 8'h3C) $display("FAIL fixed_resp_pff: got %h expected 3c", resp); else passed++;
    total++; if (dk + 1 !== 18) $display("FAIL fixed_done_latency: got %0d expected 18", dk + 1); else passed++;
    func_mode = 1'b0;
  endtask

  task automatic test_start_held();
    int d[2], r[3], nd, nr, got3;
    logic prev_busy;
    func_mode = 1'b0;
    @(posedge clk); #1;
    d = '{-1, -1}; r = '{-1, -1, -1}; nd = 0; nr = 0;
    prev_busy = bus8.busy;
    bus8.pattern_in = 8'h0F; bus8.start = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (bus8.busy && !prev_busy) begin
        if (nr < 3) r[nr] = j;
        nr++;
      end
      prev_busy = bus8.busy;
      if (bus8.done) begin
        if (nd < 2) d[nd] = j;
        nd++;
        total++; if (bus8.response !== 8'hF0) $display("FAIL held_response_%0d: got %h expected f0", nd, bus8.response); else passed++;
      end
    end
    bus8.start = 1'b0;
    total++; if (nd !== 2) $display("FAIL held_done_count: got %0d expected 2", nd); else passed++;
    total++; if (d[0] !== 17) $display("FAIL held_done1_edge: got %0d expected 17", d[0]); else passed++;
    total++; if (d[1] !== 36) $display("FAIL held_done2_edge: got %0d expected 36", d[1]); else passed++;
    total++; if (r[1] !== 19) $display("FAIL held_accept2_edge: got %0d expected 19", r[1]); else passed++;
    total++; if (nr !== 3 || r[2] !== 38) $display("FAIL held_accepts: got count %0d third %0d expected 3 and 38", nr, r[2]); else passed++;
    got3 = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (bus8.done) begin got3 = 1; break; end
    end
    total++; if (got3 !== 1) $display("FAIL held_third_done: got %0d expected 1", got3); else passed++;
  endtask

`ifdef SCAN_COMPARE_EN
  task automatic test_compare();
    logic [CL-1:0] resp, cap;
    int dk, en_low;
    func_mode = 1'b0;
    exp8 = 8'h5A;
    run_seq8(8'hA5, resp, dk, en_low, cap);
    total++; if (bus8.fail !== 1'b0) $display("FAIL cmp_match: got %b expected 0", bus8.fail); else passed++;
    exp8 = 8'h5B;
    run_seq8(8'hA5, resp, dk, en_low, cap);
    total++; if (bus8.fail !== 1'b1) $display("FAIL cmp_mismatch: got %b expected 1", bus8.fail); else passed++;
    @(posedge clk); #1;
    total++; if (bus8.fail !== 1'b1) $display("FAIL cmp_hold: got %b expected 1", bus8.fail); else passed++;
  endtask
`endif

  task automatic test_chain_len2();
    logic [CL2-1:0] resp;
    int dk;
    run_seq2(2'b10, resp, dk);
    total++; if (resp !== 2'b01) $display("FAIL len2_response: got %b expected 01", resp); else passed++;
    total++; if (dk + 1 !== 6) $display("FAIL len2_done_latency: got %0d expected 6", dk + 1); else passed++;
  endtask

  initial begin
    test_reset();
    test_inversion();
    test_mid_reset();
    test_fixed_func();
    test_start_held();
`ifdef SCAN_COMPARE_EN
    test_compare();
`endif
    test_chain_len2();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Sequencer for a chain of scanned D flip-flops; drives the chain's shared select (scan_en) and serial scan input, and receives the chain's serial scan output.
- For each test pattern: shifts the pattern in, pulses one functional capture cycle, shifts the captured response out.
- Returns the response in parallel with a done pulse.
- Sits between the test host and the scanned-FF datapath; used for structural test of the registered logic.

Parameters:
- CHAIN_LEN, 8, number of scanned FFs in the chain; legal range >= 2.
- CNT_W, $clog2(CHAIN_LEN+1), shift-counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock shared with the chain.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin one test sequence; sampled only in IDLE.
- pattern_in  input  CHAIN_LEN  pattern to load; sampled on the edge where start is accepted.
- scan_so  input  1  q of the last chain FF (FF[CHAIN_LEN-1]).
- scan_en  output  1  chain select: 1 = shift (scan data path), 0 = functional capture.
- scan_si  output  1  serial data into FF[0].
- busy  output  1  high from the accept edge until return to IDLE.
- done  output  1  one-cycle pulse; response valid from this cycle on.
- response  output  CHAIN_LEN  captured chain contents, bit k = FF[k].

Behaviour:
- Chain convention: FF[0] is fed by scan_si; data moves toward FF[CHAIN_LEN-1] one position per shift edge.
- All outputs are registered (Moore).
- Reset (rst=0, asynchronous):
  - state=IDLE, scan_en=0, scan_si=0, busy=0, done=0, response=0, internal shift registers and counter=0.
  - Takes effect immediately, including mid-sequence; the chain contents are then undefined.
  - The first sequence after reset release needs a new start.
- FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - scan_en=0, busy=0.
  - At edge E0 with start=1: latch pattern_in into pat_sr, counter=0, go to SHIFT_IN.
  - start=0: stay in IDLE.
- SHIFT_IN:
  - scan_en=1, busy=1.
  - scan_si = pat_sr MSB; pat_sr shifts left each edge, so the MSB is sent first.
  - Chain shifts at edges E1..E(CHAIN_LEN).
  - After E(CHAIN_LEN), FF[k] = pattern_in[k].
  - When counter reaches CHAIN_LEN-1, go to CAPTURE.
- CAPTURE:
  - Exactly one cycle with scan_en=0; the chain loads functional data at edge E(CHAIN_LEN+1).
  - scan_si=0.
- SHIFT_OUT:
  - scan_en=1, scan_si=0 (chain is flushed with zeros).
  - Each edge E(CHAIN_LEN+2)..E(2*CHAIN_LEN+1): resp_sr <= {resp_sr[CHAIN_LEN-2:0], scan_so}.
  - After CHAIN_LEN samples, resp_sr[k] = captured FF[k]. Go to DONE.
- DONE:
  - done=1 and scan_en=0 for one cycle.
  - response <= resp_sr on the edge entering DONE.
  - Next edge returns to IDLE; busy stays 1 until that edge.
- Latency: done is high in the cycle following edge E(2*CHAIN_LEN+1), i.e. 2*CHAIN_LEN+2 cycles after start is accepted.
- response holds its value until the next DONE or reset.
- start while busy=1 is ignored and not queued. If start is held high continuously, the next sequence is accepted on the first IDLE edge after DONE.
- pattern_in changes after the accept edge have no effect on the running sequence.
- Counter is CNT_W bits; it clears at each state transition and never wraps within a state.

Optional Feature:
- Macro: SCAN_COMPARE_EN
- Defined:
  - Adds input expected_in [CHAIN_LEN] and output fail [1].
  - expected_in is latched together with pattern_in at the accept edge.
  - fail is registered on the edge entering DONE as |(resp_sr ^ expected_latched), and holds like response.
  - fail resets to 0.
- Undefined: neither port exists, and no compare logic is built.

Test Plan:
- Bench: CHAIN_LEN=8, eight scanned-DFF instances, functional inputs driven by the bench.
- Reset mid-sequence: start with 8'hA5, drive rst=0 during SHIFT_IN cycle 3 -> scan_en, busy, done, scan_si, response all 0 immediately; no done afterwards without a new start.
- Inversion loopback: each FF's functional input = ~q, start with pattern 8'hA5 -> response=8'h5A; done exactly 18 cycles after the accept edge; scan_en low for exactly one cycle mid-sequence.
- Fixed functional data: functional inputs tied to 8'h3C, patterns 8'h00 and 8'hFF -> response=8'h3C both times.
- start held high for 40 cycles with functional=~q, pattern 8'h0F -> two complete sequences, each response=8'hF0; second accept occurs on the edge after DONE; no acceptance while busy.
- SCAN_COMPARE_EN defined, inversion loopback, pattern 8'hA5: expected 8'h5A -> fail=0; expected 8'h5B -> fail=1.
- Boundary: CHAIN_LEN=2, functional=~q, pattern 2'b10 -> response=2'b01, done 6 cycles after accept.
